// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: upstream beat (data, select, valid/ready),
// downstream beat (data, valid/ready) and the sticky select-error flag.
interface mux_n_pipe_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input registered selector with a two-entry skid buffer on a valid/ready stream.
// Define MUX_N_PIPE_SEL_CHECK_EN to build the sticky out-of-range select flag.
module mux_n_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_n_pipe_if.slave  bus
);
    localparam int SEL_W = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Out-of-range selects fall through every comparison and yield zero.
    function automatic logic [WIDTH-1:0] f_select(
        input logic [NUM_IN*WIDTH-1:0] d,
        input logic [SEL_W-1:0]        s
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(s) == k) res = d[k*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_word;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // in_ready depends only on state so out_ready never reaches it combinationally.
    assign w_in_ready = (r_state != S_FULL) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state != S_EMPTY) && bus.out_ready;
    assign w_word     = f_select(bus.in_data, bus.sel);

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = S_ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) r_main <= w_main_from_skid ? r_skid : w_word;
            if (w_load_skid) r_skid <= w_word;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.out_data  = r_main;

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic w_sel_oor;
    logic r_sel_err;

    assign w_sel_oor = (32'(bus.sel) >= NUM_IN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end

    assign bus.sel_err = r_sel_err;
`else
    assign bus.sel_err = 1'b0;
`endif
endmodule
